// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write path (AW/W/B) between NREQ masters.
// One whole transaction per grant; WLAST is regenerated from the granted AWLEN.
//
// state | meaning
// IDLE  | no owner, scanning s_awvalid from ptr
// ADDR  | presenting the owner's AW fields downstream
// DATA  | forwarding W beats, beat_cnt counts down to the last beat
// RESP  | forwarding the B response back to the owner
module axi_wr_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 64
) (
  input  logic                   axi_aclk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        s_awvalid,
  input  logic [NREQ*AW-1:0]     s_awaddr,
  input  logic [NREQ*8-1:0]      s_awlen,
  input  logic [NREQ*3-1:0]      s_awsize,
  input  logic [NREQ*2-1:0]      s_awburst,
  output logic [NREQ-1:0]        s_awready,
  input  logic [NREQ-1:0]        s_wvalid,
  input  logic [NREQ*DW-1:0]     s_wdata,
  input  logic [NREQ*DW/8-1:0]   s_wstrb,
  input  logic [NREQ-1:0]        s_wlast,
  output logic [NREQ-1:0]        s_wready,
  input  logic [NREQ-1:0]        s_bready,
  output logic [NREQ-1:0]        s_bvalid,
  output logic [1:0]             s_bresp,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [AW-1:0]          m_awaddr,
  output logic [7:0]             m_awlen,
  output logic [2:0]             m_awsize,
  output logic [1:0]             m_awburst,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  output logic [DW-1:0]          m_wdata,
  output logic [DW/8-1:0]        m_wstrb,
  output logic                   m_wlast,
  input  logic                   m_bvalid,
  output logic                   m_bready,
  input  logic [1:0]             m_bresp,
  output logic [NREQ-1:0]        grant,
  output logic                   len_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  logic            len_err_q, len_err_d;

  logic [AW-1:0]   sel_awaddr;
  logic [7:0]      sel_awlen;
  logic [2:0]      sel_awsize;
  logic [1:0]      sel_awburst;
  logic            sel_wvalid;
  logic [DW-1:0]   sel_wdata;
  logic [SW-1:0]   sel_wstrb;
  logic            sel_wlast;
  logic            sel_bready;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;

  always_comb begin
    sel_awaddr  = '0;
    sel_awlen   = '0;
    sel_awsize  = '0;
    sel_awburst = '0;
    sel_wvalid  = 1'b0;
    sel_wdata   = '0;
    sel_wstrb   = '0;
    sel_wlast   = 1'b0;
    sel_bready  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx_q == IW'(i)) begin
        sel_awaddr  = s_awaddr[i*AW +: AW];
        sel_awlen   = s_awlen[i*8 +: 8];
        sel_awsize  = s_awsize[i*3 +: 3];
        sel_awburst = s_awburst[i*2 +: 2];
        sel_wvalid  = s_wvalid[i];
        sel_wdata   = s_wdata[i*DW +: DW];
        sel_wstrb   = s_wstrb[i*SW +: SW];
        sel_wlast   = s_wlast[i];
        sel_bready  = s_bready[i];
      end
    end
  end

  // Rotating priority: indices at or above ptr first, then the wrapped ones.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && s_awvalid[i] && (IW'(i) >= ptr_q)) begin
        pick_found = 1'b1;
        pick_idx   = IW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && s_awvalid[i]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bresp   = '0;
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awsize  = '0;
    m_awburst = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    case (state_q)
      ADDR: begin
        m_awvalid         = 1'b1;
        m_awaddr          = sel_awaddr;
        m_awlen           = sel_awlen;
        m_awsize          = sel_awsize;
        m_awburst         = sel_awburst;
        s_awready[gidx_q] = m_awready;
      end
      DATA: begin
        m_wvalid         = sel_wvalid;
        m_wdata          = sel_wdata;
        m_wstrb          = sel_wstrb;
        m_wlast          = (beat_cnt_q == 8'd0);
        s_wready[gidx_q] = m_wready;
      end
      RESP: begin
        s_bvalid[gidx_q] = m_bvalid;
        m_bready         = sel_bready;
        s_bresp          = m_bresp;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          state_d           = ADDR;
        end
      end
      ADDR: begin
        if (m_awready) begin
          beat_cnt_d = sel_awlen;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (m_wvalid && m_wready) begin
          if (sel_wlast != m_wlast) len_err_d = 1'b1;
          if (m_wlast) begin
            state_d = RESP;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end
      RESP: begin
        if (m_bvalid && sel_bready) begin
          ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  assign grant   = grant_q;
  assign len_err = len_err_q;

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Round-robin arbiter sharing one AXI write path (AW, W and B channels) between NREQ upstream write masters.
- Grants one requester per complete write transaction: address, all data beats, then the response. One transaction is outstanding at a time.
- Sits in front of the write-channel protocol FSM. Regenerates WLAST from the granted AWLEN and flags upstream WLAST mismatches.

Parameters:
- NREQ, 2, number of upstream requesters (2..8).
- AW, 32, address width.
- DW, 64, write data width; strobe width is DW/8.

Ports:
- axi_aclk  in  1  clock, all logic on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- s_awvalid  in  NREQ  per-requester address valid
- s_awaddr  in  NREQ*AW  flattened; requester i occupies bits [i*AW +: AW]
- s_awlen  in  NREQ*8  flattened burst lengths
- s_awsize  in  NREQ*3  flattened burst sizes
- s_awburst  in  NREQ*2  flattened burst types
- s_awready  out  NREQ  per-requester address ready
- s_wvalid  in  NREQ  per-requester data valid
- s_wdata  in  NREQ*DW  flattened write data
- s_wstrb  in  NREQ*DW/8  flattened strobes
- s_wlast  in  NREQ  upstream last flags (checked only)
- s_wready  out  NREQ  per-requester data ready
- s_bready  in  NREQ  per-requester response ready
- s_bvalid  out  NREQ  per-requester response valid
- s_bresp  out  2  response code, broadcast to all requesters
- m_awvalid / m_awready  out / in  1  downstream address handshake
- m_awaddr, m_awlen, m_awsize, m_awburst  out  AW, 8, 3, 2  downstream address fields
- m_wvalid / m_wready  out / in  1  downstream data handshake
- m_wdata, m_wstrb, m_wlast  out  DW, DW/8, 1  downstream data fields
- m_bvalid / m_bready  in / out  1  downstream response handshake
- m_bresp  in  2  downstream response code
- grant  out  NREQ  one-hot current owner; all zero in IDLE
- len_err  out  1  sticky; set when upstream WLAST disagrees with the beat count

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE, grant=0, ptr=0, beat_cnt=0, len_err=0.
  - All m_*valid, m_bready, s_*ready and s_bvalid read 0. Data/address outputs read 0.
  - Reset mid-transaction abandons the transaction with no completion.
- Downstream outputs are combinational muxes of the granted requester's inputs, gated by state. Outside their phase they are 0.
- States: IDLE, ADDR, DATA, RESP (2-bit encoding).
- IDLE:
  - If any s_awvalid bit is set, register grant = first set bit scanning ptr, ptr+1, ... wrapping mod NREQ. Next state ADDR.
  - Latency: s_awvalid high at cycle 0 gives m_awvalid at cycle 1.
- ADDR:
  - m_awvalid=1 with the granted fields; s_awready[g]=m_awready.
  - On the handshake: load beat_cnt=m_awlen, go to DATA.
  - awlen=255 means 256 beats (8-bit counter, no overflow).
- DATA:
  - m_wvalid=s_wvalid[g]; s_wready[g]=m_wready; m_wlast=(beat_cnt==0).
  - Each handshake decrements beat_cnt.
  - On a handshake with m_wlast=1, go to RESP.
  - Any handshake with s_wlast[g]!=m_wlast sets len_err. len_err stays set until reset; the transfer continues on the arbiter's count.
- RESP:
  - s_bvalid[g]=m_bvalid; m_bready=s_bready[g]; s_bresp=m_bresp.
  - On the handshake: ptr=(g+1) mod NREQ, grant=0, next state IDLE.
  - The earliest next grant is 1 cycle later; there is one idle bubble between transactions.
- Non-granted requesters always see s_awready=s_wready=s_bvalid=0. Their valid inputs may stay high indefinitely.
- Upstream valids dropping mid-phase just stall; the arbiter does not time out.
- Upstream s_awvalid may deassert in ADDR before the handshake; the arbiter still presents m_awvalid. An AXI-compliant requester never does this.
- Fairness: with all requesters active continuously, grants rotate 0,1,...,NREQ-1,0.

Test Plan:
- Single requester 1, awlen=3, no stalls -> m_awvalid at cycle 1; 4 W beats with m_wlast only on the 4th; s_bvalid[1] follows m_bvalid; grant back to 0 one cycle after B handshake.
- NREQ=2, both s_awvalid high from reset, back-to-back 1-beat writes -> grant sequence 01,10,01,10 (one-hot); each grant holds until its B handshake.
- m_awready low for 5 cycles, m_wready toggling 1,0,1 -> m_awvalid and fields stay stable; beat_cnt decrements only on handshake cycles; no lost or duplicated beats.
- awlen=255 -> exactly 256 W handshakes, m_wlast on beat 256 only, then RESP.
- Requester asserts s_wlast on beat 2 of awlen=3 -> len_err=1 from the next cycle and stays set; m_wlast still on beat 4; transaction completes normally.
- rst_n pulsed low in the middle of DATA -> all outputs 0 immediately with no clock edge; after release a new request to requester 0 is granted (ptr=0).
